// File: rtl/spi_seq_pkg.sv
// Shared types and default constants for the SPI transaction sequencer.
package spi_seq_pkg;

  localparam int SPI_BYTE_W     = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_START_TO   = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_STORE,
    S_GAP
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy level, used for both the TX and RX byte queues.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_level == FULL_LEVEL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Byte-stream front end for the SPI master controller: queues host TX bytes,
// runs one controller transfer per byte and returns received bytes in order.
module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int START_TO   = DEF_START_TO
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SPI_BYTE_W-1:0]   i_tx_data,
  input  logic                    i_tx_valid,
  output logic                    o_tx_ready,
  output logic [SPI_BYTE_W-1:0]   o_rx_data,
  output logic                    o_rx_valid,
  input  logic                    i_rx_ready,
  output logic                    o_spi_start,
  output logic [SPI_BYTE_W-1:0]   o_spi_in_data,
  input  logic [SPI_BYTE_W-1:0]   i_spi_out_data,
  input  logic                    i_spi_cs,
  output logic                    o_busy,
  output logic [$clog2(DEPTH):0]  o_tx_level,
  output logic [$clog2(DEPTH):0]  o_rx_level,
  output logic                    o_err_timeout,
  input  logic                    i_err_clr
);

  localparam int TO_W  = $clog2(START_TO + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TO - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t                  r_state;
  logic                    r_spi_start;
  logic [SPI_BYTE_W-1:0]   r_spi_in_data;
  logic [TO_W-1:0]         r_to_cnt;
  logic [GAP_W-1:0]        r_gap_cnt;
  logic                    r_busy;
  logic                    r_err;

  logic [SPI_BYTE_W-1:0]   w_tx_head;
  logic                    w_tx_full;
  logic                    w_tx_empty;
  logic                    w_rx_full;
  logic                    w_rx_empty;
  logic                    w_tx_push;
  logic                    w_tx_pop;
  logic                    w_rx_push;
  logic                    w_rx_pop;
  logic                    w_timeout_hit;

  assign o_tx_ready    = !w_tx_full;
  assign o_rx_valid    = !w_rx_empty;
  assign w_tx_push     = i_tx_valid && o_tx_ready;
  assign w_rx_pop      = i_rx_ready && o_rx_valid;
  assign w_timeout_hit = (r_state == S_WAIT_LOW) && i_spi_cs && (r_to_cnt == TO_LAST);
  assign w_rx_push     = (r_state == S_STORE);
  assign w_tx_pop      = (r_state == S_STORE) || w_timeout_hit;

  assign o_spi_start   = r_spi_start;
  assign o_spi_in_data = r_spi_in_data;
  assign o_busy        = r_busy;
  assign o_err_timeout = r_err;

  sync_fifo #(
    .W     (SPI_BYTE_W),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_wdata (i_tx_data),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_level (o_tx_level),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  sync_fifo #(
    .W     (SPI_BYTE_W),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_wdata (i_spi_out_data),
    .i_pop   (w_rx_pop),
    .o_rdata (o_rx_data),
    .o_level (o_rx_level),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Transfer sequencing: launch only with RX room so a started byte always has a home.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_spi_start   <= 1'b0;
      r_spi_in_data <= '0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_spi_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_tx_empty && !w_rx_full && i_spi_cs) begin
            r_spi_in_data <= w_tx_head;
            r_spi_start   <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!i_spi_cs) begin
            r_state <= S_WAIT_HIGH;
          end else if (w_timeout_hit) begin
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (i_spi_cs) begin
            r_state <= S_STORE;
          end
        end
        S_STORE: begin
          r_gap_cnt <= '0;
          r_state   <= S_GAP;
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag; a fresh timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_timeout_hit) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Bench for spi_txn_sequencer paired with a small SPI controller/slave model.
module tb_spi_txn_sequencer;

  localparam int DEPTH      = 8;
  localparam int GAP_CYCLES = 2;
  localparam int START_TO   = 15;

  typedef struct {
    logic [7:0] txByte;
    logic [7:0] expRx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] txData = '0;
  logic       txValid = 1'b0;
  logic       txReady;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady = 1'b0;
  logic       spiStart;
  logic [7:0] spiInData;
  logic [7:0] spiOutData = '0;
  logic       spiCs = 1'b1;
  logic       busy;
  logic [3:0] txLevel;
  logic [3:0] rxLevel;
  logic       errTimeout;
  logic       errClr = 1'b0;

  logic       ctrlMute = 1'b0;
  logic       inDataGlitch = 1'b0;
  logic [7:0] ctlLatched = '0;
  int         ctlPhase = 0;
  int         ctlCnt = 0;

  int         startCount = 0;
  logic       prevStart = 1'b0;
  logic       startWide = 1'b0;
  int         csHighRun = 0;
  logic       csSeenLow = 1'b0;
  int         minGap = 1000;

  int         checks = 0;
  int         passed = 0;
  vec_t       vecs [9];

  spi_txn_sequencer #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP_CYCLES),
    .START_TO   (START_TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rstN),
    .i_tx_data      (txData),
    .i_tx_valid     (txValid),
    .o_tx_ready     (txReady),
    .o_rx_data      (rxData),
    .o_rx_valid     (rxValid),
    .i_rx_ready     (rxReady),
    .o_spi_start    (spiStart),
    .o_spi_in_data  (spiInData),
    .i_spi_out_data (spiOutData),
    .i_spi_cs       (spiCs),
    .o_busy         (busy),
    .o_tx_level     (txLevel),
    .o_rx_level     (rxLevel),
    .o_err_timeout  (errTimeout),
    .i_err_clr      (errClr)
  );

  always #5 clk = ~clk;

  // Controller + slave model: CS low 3 cycles after start, 6 cycles low, slave answers byte ^ 0x99.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      spiCs      <= 1'b1;
      spiOutData <= '0;
      ctlPhase   <= 0;
      ctlCnt     <= 0;
      ctlLatched <= '0;
    end else begin
      case (ctlPhase)
        0: if (spiStart && !ctrlMute) begin
             ctlLatched <= spiInData;
             ctlCnt     <= 0;
             ctlPhase   <= 1;
           end
        1: if (ctlCnt == 2) begin
             spiCs    <= 1'b0;
             ctlCnt   <= 0;
             ctlPhase <= 2;
           end else begin
             ctlCnt <= ctlCnt + 1;
           end
        2: begin
             if (spiInData != ctlLatched) inDataGlitch <= 1'b1;
             if (ctlCnt == 5) begin
               spiOutData <= ctlLatched ^ 8'h99;
               spiCs      <= 1'b1;
               ctlPhase   <= 0;
             end else begin
               ctlCnt <= ctlCnt + 1;
             end
           end
        default: ctlPhase <= 0;
      endcase
    end
  end

  // Count start pulses and note any that stay high for more than one cycle.
  always @(posedge clk) begin
    prevStart <= spiStart;
    if (spiStart) startCount <= startCount + 1;
    if (spiStart && prevStart) startWide <= 1'b1;
  end

  // Track the shortest CS-high stretch between transfers.
  always @(posedge clk) begin
    if (spiCs) begin
      csHighRun <= csHighRun + 1;
    end else begin
      if (csHighRun > 0 && csSeenLow && csHighRun < minGap) minGap <= csHighRun;
      csHighRun <= 0;
      csSeenLow <= 1'b1;
    end
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push one byte into the TX stream, waiting (bounded) for room.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCnt;
    waitCnt = 0;
    txData  = b;
    txValid = 1'b1;
    while (!txReady && waitCnt < 500) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    if (!txReady) checkOutput("push_ready_wait", int'(txReady), 1);
    @(posedge clk);
    #1;
    txValid = 1'b0;
  endtask

  task automatic popRx(input logic [7:0] expected, input string name);
    checkOutput({name, "_valid"}, int'(rxValid), 1);
    checkOutput({name, "_data"}, int'(rxData), int'(expected));
    rxReady = 1'b1;
    @(posedge clk);
    #1;
    rxReady = 1'b0;
  endtask

  initial begin
    int   waitCnt;
    int   base;
    logic prevCs;
    logic edgeSeen;

    vecs[0] = '{8'h00, 8'h99};
    vecs[1] = '{8'hFF, 8'h66};
    vecs[2] = '{8'h5A, 8'hC3};
    vecs[3] = '{8'h12, 8'h8B};
    vecs[4] = '{8'h80, 8'h19};
    vecs[5] = '{8'h01, 8'h98};
    vecs[6] = '{8'h7E, 8'hE7};
    vecs[7] = '{8'hC3, 8'h5A};
    vecs[8] = '{8'h3E, 8'hA7};

    // Reset state
    waitCycles(3);
    checkOutput("rst_tx_ready", int'(txReady), 1);
    checkOutput("rst_rx_valid", int'(rxValid), 0);
    checkOutput("rst_rx_data", int'(rxData), 0);
    checkOutput("rst_spi_start", int'(spiStart), 0);
    checkOutput("rst_spi_in_data", int'(spiInData), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_levels", int'({txLevel, rxLevel}), 0);
    checkOutput("rst_err", int'(errTimeout), 0);
    rstN = 1'b1;
    waitCycles(2);

    // Single byte, including launch latency
    applyStimulus(8'hA5);
    checkOutput("single_tx_level", int'(txLevel), 1);
    checkOutput("single_no_early_start", int'(spiStart), 0);
    waitCycles(1);
    checkOutput("single_start", int'(spiStart), 1);
    checkOutput("single_in_data", int'(spiInData), 8'hA5);
    waitCnt = 0;
    while (!rxValid && waitCnt < 200) begin waitCycles(1); waitCnt++; end
    checkOutput("single_tx_level_after", int'(txLevel), 0);
    popRx(8'h3C, "single_rx");
    checkOutput("single_start_count", startCount, 1);

    // Burst of eight with the host not reading
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i].txByte);
    checkOutput("burst_tx_ready_low", int'(txReady), 0);
    checkOutput("burst_tx_level", int'(txLevel), 8);
    waitCnt = 0;
    while (rxLevel != 4'd8 && waitCnt < 1000) begin waitCycles(1); waitCnt++; end
    checkOutput("burst_rx_level", int'(rxLevel), 8);
    checkOutput("burst_start_count", startCount, 9);
    for (int i = 0; i < 8; i++) popRx(vecs[i].expRx, $sformatf("burst_rx%0d", i));
    waitCnt = 0;
    while (busy && waitCnt < 100) begin waitCycles(1); waitCnt++; end

    // RX full stalls launches; one pop lets the ninth transfer through
    base = startCount;
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i].txByte);
    waitCnt = 0;
    while (rxLevel != 4'd8 && waitCnt < 1000) begin waitCycles(1); waitCnt++; end
    waitCycles(40);
    checkOutput("full_rx_level", int'(rxLevel), 8);
    checkOutput("full_busy", int'(busy), 0);
    checkOutput("full_start_count", startCount - base, 8);
    checkOutput("full_tx_level", int'(txLevel), 1);
    popRx(vecs[0].expRx, "full_pop0");
    waitCnt = 0;
    while (startCount - base != 9 && waitCnt < 100) begin waitCycles(1); waitCnt++; end
    checkOutput("full_ninth_launch", startCount - base, 9);

    // STORE coinciding with a host pop keeps the level and loses nothing
    prevCs = spiCs;
    edgeSeen = 1'b0;
    waitCnt = 0;
    while (!edgeSeen && waitCnt < 200) begin
      waitCycles(1);
      waitCnt++;
      if (spiCs && !prevCs) edgeSeen = 1'b1;
      prevCs = spiCs;
    end
    checkOutput("simul_cs_rise", int'(edgeSeen), 1);
    waitCycles(1);
    checkOutput("simul_level_before", int'(rxLevel), 7);
    rxReady = 1'b1;
    checkOutput("simul_pop_data", int'(rxData), int'(vecs[1].expRx));
    waitCycles(1);
    rxReady = 1'b0;
    checkOutput("simul_rx_level", int'(rxLevel), 7);
    checkOutput("simul_tx_level", int'(txLevel), 0);
    for (int i = 2; i < 9; i++) popRx(vecs[i].expRx, $sformatf("simul_rx%0d", i));
    checkOutput("simul_drained", int'(rxValid), 0);
    waitCnt = 0;
    while (busy && waitCnt < 100) begin waitCycles(1); waitCnt++; end

    // Timeout: controller never drops CS
    ctrlMute = 1'b1;
    applyStimulus(8'h42);
    waitCnt = 0;
    while (!spiStart && waitCnt < 50) begin waitCycles(1); waitCnt++; end
    checkOutput("to_launch", int'(spiStart), 1);
    waitCycles(START_TO);
    checkOutput("to_not_early", int'(errTimeout), 0);
    waitCnt = 0;
    while (!errTimeout && waitCnt < 4) begin waitCycles(1); waitCnt++; end
    checkOutput("to_flag", int'(errTimeout), 1);
    waitCnt = 0;
    while (busy && waitCnt < 50) begin waitCycles(1); waitCnt++; end
    checkOutput("to_idle", int'(busy), 0);
    checkOutput("to_tx_dropped", int'(txLevel), 0);
    checkOutput("to_no_rx", int'(rxLevel), 0);
    waitCycles(3);
    checkOutput("to_sticky", int'(errTimeout), 1);
    errClr = 1'b1;
    waitCycles(1);
    errClr = 1'b0;
    checkOutput("to_clear", int'(errTimeout), 0);

    // Clear held across a new timeout: the set must win
    errClr = 1'b1;
    applyStimulus(8'h43);
    waitCnt = 0;
    while (!errTimeout && waitCnt < 60) begin waitCycles(1); waitCnt++; end
    checkOutput("to_set_beats_clr", int'(errTimeout), 1);
    errClr = 1'b0;
    waitCycles(1);
    checkOutput("to_set_holds", int'(errTimeout), 1);
    waitCnt = 0;
    while (busy && waitCnt < 50) begin waitCycles(1); waitCnt++; end
    ctrlMute = 1'b0;

    // Reset while the controller has CS low
    applyStimulus(8'h77);
    waitCnt = 0;
    while (spiCs && waitCnt < 50) begin waitCycles(1); waitCnt++; end
    waitCycles(2);
    checkOutput("mid_in_transfer", int'({busy, spiCs}), 2);
    rstN = 1'b0;
    #1;
    checkOutput("mid_levels", int'({txLevel, rxLevel}), 0);
    checkOutput("mid_spi_start", int'(spiStart), 0);
    checkOutput("mid_tx_ready", int'(txReady), 1);
    checkOutput("mid_err", int'(errTimeout), 0);
    base = startCount;
    waitCycles(2);
    rstN = 1'b1;
    waitCycles(30);
    checkOutput("mid_no_rx_push", int'(rxLevel), 0);
    checkOutput("mid_no_relaunch", startCount - base, 0);
    checkOutput("mid_idle", int'(busy), 0);

    // Whole-run properties
    checkOutput("start_one_cycle", int'(startWide), 0);
    checkOutput("in_data_stable", int'(inDataGlitch), 0);
    checkOutput("cs_gap_min", int'(minGap >= GAP_CYCLES), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
